// File: rtl/clk_period_monitor.sv
// ---------------------------------------------------------------------------
// clk_period_monitor
//
// Measures an externally generated clock (clk_in) against the sampling clock
// (clk). For every complete cycle of clk_in it reports the period and high
// time in clk cycles, tracks the min/max period since reset or clear, flags
// periods outside NOM_PERIOD +/- TOL, and detects a non-toggling input.
//
// Ports:
//   clk           in   sampling clock, rising edge
//   rst           in   asynchronous active-high reset
//   clk_in        in   monitored clock, asynchronous to clk
//   stats_clr     in   synchronous pulse; resets min/max and jitter_sticky
//   period        out  last measured period (clk cycles)
//   high_time     out  high time of the last measured period (clk cycles)
//   min_period    out  smallest period since reset/clear (all ones if none)
//   max_period    out  largest period since reset/clear (0 if none)
//   meas_valid    out  one-cycle pulse when period/high_time update
//   jitter_err    out  one-cycle pulse with meas_valid when out of tolerance
//   jitter_sticky out  set by jitter_err, held until stats_clr
//   stuck         out  high while clk_in has not toggled for TIMEOUT cycles
// ---------------------------------------------------------------------------
module clk_period_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned NOM_PERIOD = 100,
  parameter int unsigned TOL        = 5,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period,
  output logic             meas_valid,
  output logic             jitter_err,
  output logic             jitter_sticky,
  output logic             stuck
);

  localparam int unsigned       IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]    NOM_X    = (CNT_W + 1)'(NOM_PERIOD);
  localparam logic [CNT_W:0]    TOL_X    = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_STUCK
  } state_e;

  // Synchronizer and edge detector
  logic              sync1_q;
  logic              s_q;
  logic              p_q;
  logic [2:0]        prime_q;
  logic [2:0]        prime_d;

  // Control state and counters
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0]  hi_stage_q, hi_stage_d;

  // Measurement outputs
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic [CNT_W-1:0]  min_q, min_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic              mv_q, mv_d;
  logic              je_q, je_d;
  logic              sticky_q, sticky_d;
  logic              stuck_q, stuck_d;

  // Combinational helpers
  logic              rise;
  logic              fall;
  logic              timeout;
  logic              take_meas;
  logic [CNT_W-1:0]  meas_hi;
  logic [CNT_W:0]    per_x;
  logic [CNT_W:0]    dev;
  logic              jit;

  // Edges are only qualified once s and p both hold post-reset samples of
  // clk_in, so releasing reset while clk_in is high does not look like a rise.
  always_comb begin
    prime_d = {prime_q[1:0], 1'b1};
    rise    = prime_q[2] & s_q & ~p_q;
    fall    = prime_q[2] & ~s_q & p_q;
  end

  always_comb begin
    if (rise) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (rise || fall) begin
      idle_d = '0;
    end else if (idle_q == IDLE_MAX) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    // Fires on the edge at which idle_q reaches TIMEOUT.
    timeout = (idle_d == IDLE_MAX);
  end

  // Deviation from nominal, one bit wider than the counter so it cannot wrap.
  always_comb begin
    per_x = {1'b0, cnt_q};
    if (per_x >= NOM_X) begin
      dev = per_x - NOM_X;
    end else begin
      dev = NOM_X - per_x;
    end
    jit = (dev > TOL_X);
  end

  always_comb begin
    state_d    = state_q;
    hi_stage_d = hi_stage_q;
    take_meas  = 1'b0;
    meas_hi    = hi_stage_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          hi_stage_d = cnt_q;
          state_d    = ST_LOW;
        end else if (rise) begin
          // Low phase was too short to see: whole period counts as high.
          take_meas = 1'b1;
          meas_hi   = cnt_q;
        end
      end
      ST_LOW: begin
        if (rise) begin
          take_meas = 1'b1;
          state_d   = ST_HIGH;
        end
      end
      ST_STUCK: begin
        if (rise) begin
          state_d = ST_HIGH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A timeout implies no edge this cycle, so it never competes with take_meas.
    if (timeout) begin
      state_d = ST_STUCK;
    end
  end

  // Clear is applied before the new sample so a coincident measurement wins.
  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    min_d    = stats_clr ? '1 : min_q;
    max_d    = stats_clr ? '0 : max_q;
    sticky_d = stats_clr ? 1'b0 : sticky_q;
    mv_d     = take_meas;
    je_d     = take_meas & jit;
    stuck_d  = (state_d == ST_STUCK);

    if (take_meas) begin
      period_d = cnt_q;
      high_d   = meas_hi;
      if (cnt_q < min_d) begin
        min_d = cnt_q;
      end
      if (cnt_q > max_d) begin
        max_d = cnt_q;
      end
      if (jit) begin
        sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      s_q        <= 1'b0;
      p_q        <= 1'b0;
      prime_q    <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idle_q     <= '0;
      hi_stage_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      min_q      <= '1;
      max_q      <= '0;
      mv_q       <= 1'b0;
      je_q       <= 1'b0;
      sticky_q   <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      sync1_q    <= clk_in;
      s_q        <= sync1_q;
      p_q        <= s_q;
      prime_q    <= prime_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      hi_stage_q <= hi_stage_d;
      period_q   <= period_d;
      high_q     <= high_d;
      min_q      <= min_d;
      max_q      <= max_d;
      mv_q       <= mv_d;
      je_q       <= je_d;
      sticky_q   <= sticky_d;
      stuck_q    <= stuck_d;
    end
  end

  assign period        = period_q;
  assign high_time     = high_q;
  assign min_period    = min_q;
  assign max_period    = max_q;
  assign meas_valid    = mv_q;
  assign jitter_err    = je_q;
  assign jitter_sticky = sticky_q;
  assign stuck         = stuck_q;

endmodule
